serializer_tx_arbiter: RTL and testbench

- Shares the single serializer (1024-bit frame → 64-bit Aurora TX beats) among NUM_REQ local requesters, e.g. host DMA, forwarding path and control messages.
- Round-robin picks one pending request and latches its frame, destination, TTL and router ID.
- Issues the one-cycle send_data_valid launch pulse and holds the serializer inputs stable until done_serializer.
- Sits between the requester FIFOs and the serializer in the router TX path.

---
 rtl/serializer_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/serializer_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_serializer_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared widths, request record and FSM state encoding for the serializer TX arbiter.
package serializer_pkg;

  localparam int SEND_DATA_WIDTH = 1024;
  localparam int ADDR_WIDTH      = 10;
  localparam int TTL_W           = 2;
  localparam int ROUTER_ID_W     = 2;

  typedef struct packed {
    logic [SEND_DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0]      dst_addr;
    logic [TTL_W-1:0]           ttl;
    logic [ROUTER_ID_W-1:0]     router_id;
  } send_req_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request found searching upward from last_grant+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // Modulo keeps the wrap correct when NUM_REQ is not a power of two.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/serializer_tx_arbiter.sv
// Round-robin owner of the shared TX serializer: grants, latches and launches one frame at a time.
// Optional WAIT_DONE watchdog is built only when SER_WATCHDOG_EN is defined.
module serializer_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SEND_DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH      = 10,
  parameter int WDOG_CYCLES     = 256
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*SEND_DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_dst_addr,
  input  logic [NUM_REQ*serializer_pkg::TTL_W-1:0]       req_ttl,
  input  logic [NUM_REQ*serializer_pkg::ROUTER_ID_W-1:0] req_router_id,
  output logic [NUM_REQ-1:0]                     req_done,
  output logic                                   send_data_valid,
  output logic [SEND_DATA_WIDTH-1:0]             v_data_read,
  output logic [ADDR_WIDTH-1:0]                  dst_addr_send,
  output logic [serializer_pkg::TTL_W-1:0]       TTL_send,
  output logic [serializer_pkg::ROUTER_ID_W-1:0] router_id_send,
  input  logic                                   done_serializer,
  output logic                                   busy,
  output logic [$clog2(NUM_REQ)-1:0]             grant_id,
  output logic                                   timeout_err
);
  import serializer_pkg::*;

  localparam int GW = $clog2(NUM_REQ);

  arb_state_t state;
  logic [GW-1:0] last_grant;

  logic [SEND_DATA_WIDTH-1:0] data_arr   [NUM_REQ];
  logic [ADDR_WIDTH-1:0]      dst_arr    [NUM_REQ];
  logic [TTL_W-1:0]           ttl_arr    [NUM_REQ];
  logic [ROUTER_ID_W-1:0]     rid_arr    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*SEND_DATA_WIDTH +: SEND_DATA_WIDTH];
    assign dst_arr[i]  = req_dst_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign ttl_arr[i]  = req_ttl[i*TTL_W +: TTL_W];
    assign rid_arr[i]  = req_router_id[i*ROUTER_ID_W +: ROUTER_ID_W];
  end

  logic [NUM_REQ-1:0] pick;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  // The accept strobe is the live pick, so it can only appear while idle.
  assign req_ready = (state == IDLE) ? pick : '0;

`ifdef SER_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  logic [WDOG_W-1:0] wdog;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= GW'(NUM_REQ - 1);
      grant_id        <= '0;
      busy            <= 1'b0;
      send_data_valid <= 1'b0;
      req_done        <= '0;
      v_data_read     <= '0;
      dst_addr_send   <= '0;
      TTL_send        <= '0;
      router_id_send  <= '0;
`ifdef SER_WATCHDOG_EN
      timeout_err     <= 1'b0;
      wdog            <= '0;
`endif
    end else begin
      req_done        <= '0;
      send_data_valid <= 1'b0;
`ifdef SER_WATCHDOG_EN
      timeout_err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            v_data_read     <= data_arr[pick_idx];
            dst_addr_send   <= dst_arr[pick_idx];
            TTL_send        <= ttl_arr[pick_idx];
            router_id_send  <= rid_arr[pick_idx];
            grant_id        <= pick_idx;
            busy            <= 1'b1;
            send_data_valid <= 1'b1;
            state           <= LAUNCH;
          end
        end
        // done_serializer is deliberately not looked at here: a stale done must not close this transfer.
        LAUNCH: begin
          state <= WAIT_DONE;
`ifdef SER_WATCHDOG_EN
          wdog  <= '0;
`endif
        end
        WAIT_DONE: begin
          if (done_serializer) begin
            req_done[grant_id] <= 1'b1;
            last_grant         <= grant_id;
            busy               <= 1'b0;
            state              <= IDLE;
          end
`ifdef SER_WATCHDOG_EN
          else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx_arbiter.sv
// Directed bench for serializer_tx_arbiter with a queue of expected grants (SER_WATCHDOG_EN adds watchdog steps).
module tb_serializer_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 1024;
  localparam int AW = 10;
  localparam int GW = 2;
`ifdef SER_WATCHDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 256;
`endif
  localparam int T1_DLY = (WD > 20) ? 19 : 10;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready, req_done;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_dst_addr;
  logic [N*2-1:0]  req_ttl, req_router_id;
  logic            send_data_valid, done_serializer, busy, timeout_err;
  logic [DW-1:0]   v_data_read;
  logic [AW-1:0]   dst_addr_send;
  logic [1:0]      TTL_send, router_id_send;
  logic [GW-1:0]   grant_id;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [AW-1:0] dst;
    logic [1:0]    ttl;
    logic [1:0]    rid;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] tdata [N];
  logic [AW-1:0] tdst  [N];
  logic [1:0]    tttl  [N];
  logic [1:0]    trid  [N];

  always #5 clk = ~clk;

  serializer_tx_arbiter #(
    .NUM_REQ         (N),
    .SEND_DATA_WIDTH (DW),
    .ADDR_WIDTH      (AW),
    .WDOG_CYCLES     (WD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_dst_addr    (req_dst_addr),
    .req_ttl         (req_ttl),
    .req_router_id   (req_router_id),
    .req_done        (req_done),
    .send_data_valid (send_data_valid),
    .v_data_read     (v_data_read),
    .dst_addr_send   (dst_addr_send),
    .TTL_send        (TTL_send),
    .router_id_send  (router_id_send),
    .done_serializer (done_serializer),
    .busy            (busy),
    .grant_id        (grant_id),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed(low200)=%0h expected(low200)=%0h", tag, obs[199:0], expv[199:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a,
                         input logic [1:0] t, input logic [1:0] r);
    tdata[i] = d; tdst[i] = a; tttl[i] = t; trid[i] = r;
    req_data[i*DW +: DW]       = d;
    req_dst_addr[i*AW +: AW]   = a;
    req_ttl[i*2 +: 2]          = t;
    req_router_id[i*2 +: 2]    = r;
  endtask

  task automatic push(input int i);
    sb.push_back('{i, tdata[i], tdst[i], tttl[i], trid[i]});
  endtask

  // One full grant/launch/wait/done cycle, starting in IDLE with the request already pending.
  task automatic transfer(input int done_dly, input bit drop, input int raise_mid);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("ready_onehot", req_ready, 4'b0001 << e.id);
    chk("sdv_idle", send_data_valid, 0);
    step();
    if (drop) req_valid[e.id] = 1'b0;
    chk("sdv_launch", send_data_valid, 1);
    chk("grant_id", grant_id, e.id);
    chk("busy_launch", busy, 1);
    chk("data", v_data_read, e.data);
    chk("dst", dst_addr_send, e.dst);
    chk("ttl", TTL_send, e.ttl);
    chk("rid", router_id_send, e.rid);
    chk("ready_launch", req_ready, 0);
    chk("timeout_launch", timeout_err, 0);
    for (int k = 0; k < done_dly; k++) begin
      step();
      chk("sdv_wait", send_data_valid, 0);
      chk("busy_wait", busy, 1);
      chk("ready_wait", req_ready, 0);
      chk("done_wait", req_done, 0);
      chk("timeout_wait", timeout_err, 0);
      if (raise_mid >= 0 && k == 0) req_valid[raise_mid] = 1'b1;
    end
    chk("data_hold", v_data_read, e.data);
    chk("dst_hold", dst_addr_send, e.dst);
    chk("grant_hold", grant_id, e.id);
    done_serializer = 1'b1;
    step();
    done_serializer = 1'b0;
    chk("req_done", req_done, 4'b0001 << e.id);
    chk("busy_done", busy, 0);
    chk("sdv_done", send_data_valid, 0);
    chk("timeout_done", timeout_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    logic [63:0] w;
    rst = 1'b1;
    req_valid = '0;
    done_serializer = 1'b0;
    req_data = '0; req_dst_addr = '0; req_ttl = '0; req_router_id = '0;
    for (int i = 0; i < N; i++) begin
      w = {48'hC0DE_FACE_0BAD, 16'(i)};
      set_req(i, {16{w}}, AW'(256 + i), 2'(i), 2'(3 - i));
    end
    set_req(2, {512{2'b01}}, 10'h1AA, 2'b10, 2'b11);

    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_sdv", send_data_valid, 0);
    chk("rst_done", req_done, 0);
    chk("rst_data", v_data_read, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    step();

    // Single request on requester 2, done 19 cycles after launch
    req_valid = 4'b0100;
    push(2);
    transfer(T1_DLY, 1'b1, -1);

    // Reset in WAIT_DONE with grant 2
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    step(); step();
    chk("pre_rst_grant", grant_id, 2);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_data", v_data_read, 0);
    chk("arst_dst", dst_addr_send, 0);
    chk("arst_ttl", TTL_send, 0);
    chk("arst_rid", router_id_send, 0);
    chk("arst_sdv", send_data_valid, 0);
    chk("arst_done", req_done, 0);
    step();
    done_serializer = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_no_done", req_done, 0);
    done_serializer = 1'b0;
    step();
    chk("post_rst_no_done2", req_done, 0);
    chk("post_rst_busy", busy, 0);

    // All requesters pending: 0,1,2,3,0
    req_valid = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    for (int t = 0; t < 5; t++) transfer(5, 1'b0, -1);
    req_valid = 4'b0000;

    // Requester 1 re-requests after its done while 3 is pending
    step();
    req_valid = 4'b0010;
    push(1);
    transfer(5, 1'b1, 3);
    req_valid[1] = 1'b1;
    push(3);
    transfer(5, 1'b1, -1);
    push(1);
    transfer(5, 1'b1, -1);

    // Stale done while idle must not complete the next transfer
    done_serializer = 1'b1;
    step();
    chk("idle_done_nodone", req_done, 0);
    chk("idle_done_busy", busy, 0);
    step();
    chk("idle_done_nodone2", req_done, 0);
    done_serializer = 1'b0;
    step();
    req_valid[0] = 1'b1;
    push(0);
    transfer(8, 1'b1, -1);

`ifdef SER_WATCHDOG_EN
    // done on the very last watchdog cycle completes normally
    req_valid[1] = 1'b1;
    push(1);
    transfer(16, 1'b1, -1);

    // No done: watchdog fires 16 cycles into WAIT_DONE
    req_valid[2] = 1'b1;
    #1;
    chk("wd_ready", req_ready, 4'b0100);
    step();
    req_valid[2] = 1'b0;
    chk("wd_launch", send_data_valid, 1);
    step();
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    n = 0;
    while (n < 40 && timeout_err !== 1'b1) begin
      step();
      n++;
    end
    chk("wd_cycles", n, 16);
    chk("wd_pulse", timeout_err, 1);
    chk("wd_no_done", req_done, 0);
    chk("wd_busy", busy, 0);
    chk("wd_next_ready", req_ready, 4'b1000);
    push(3);
    transfer(5, 1'b1, -1);
    push(0);
    transfer(5, 1'b1, -1);
`endif

    step();
    chk("final_idle_busy", busy, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
